// File: rtl/rr_onehot_request_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_pkg : shared arbiter types, limits and one-hot index helper
// Rev 1.0
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int ARB_N_MAX     = 16;
  localparam int ARB_IDX_W_MAX = $clog2(ARB_N_MAX);

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // OR-reduction encode; only meaningful for one-hot or all-zero input.
  function automatic logic [ARB_IDX_W_MAX-1:0] onehot_to_idx(input logic [ARB_N_MAX-1:0] oh);
    logic [ARB_IDX_W_MAX-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_N_MAX; i++) begin
      if (oh[i]) idx = idx | ARB_IDX_W_MAX'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_priority_pick : rotating find-first-set over (req & mask) starting at ptr
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [N-1:0]     mask_i,
  output logic [N-1:0]     winner_onehot_o,
  output logic [IDX_W-1:0] winner_idx_o,
  output logic             any_o
);

  logic [N-1:0]   masked;
  logic [2*N-1:0] dbl;
  logic           found;

  // Duplicating the vector turns the wrap-around search into a linear one
  // over positions ptr .. ptr+N-1.
  always_comb begin
    masked       = req_i & mask_i;
    dbl          = {masked, masked};
    found        = 1'b0;
    winner_idx_o = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (!found && dbl[i] && (i >= int'(ptr_i))) begin
        found        = 1'b1;
        winner_idx_o = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
      end
    end
    any_o           = |masked;
    winner_onehot_o = any_o ? (N'(1) << winner_idx_o) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/rr_onehot_request_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_onehot_request_arbiter : round-robin one-hot grant with ack and watchdog
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_onehot_request_arbiter
  import arb_pkg::*;
#(
  parameter int N       = 16,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant_onehot,
  output logic         grant_valid,
  input  logic         grant_ack,
  output logic         timeout_pulse
);

  localparam int            IDX_W   = $clog2(N);
  localparam bit            WD_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             pulse_q, pulse_d;
  logic [TW-1:0]    cnt_q, cnt_d;

  logic [IDX_W-1:0] gidx, ptr_next, pick_ptr, win_idx;
  logic [N-1:0]     pick_mask, win_oh;
  logic             win_any;

  assign gidx     = IDX_W'(onehot_to_idx(ARB_N_MAX'(grant_q)));
  assign ptr_next = (gidx == IDX_W'(N - 1)) ? '0 : gidx + IDX_W'(1);

  rr_priority_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i           (req),
    .ptr_i           (pick_ptr),
    .mask_i          (pick_mask),
    .winner_onehot_o (win_oh),
    .winner_idx_o    (win_idx),
    .any_o           (win_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    pulse_d   = 1'b0;
    cnt_d     = cnt_q;
    pick_ptr  = ptr_q;
    pick_mask = '1;
    case (state_q)
      ARB_IDLE: begin
        grant_d = win_oh;
        valid_d = win_any;
        cnt_d   = '0;
        if (win_any) state_d = ARB_GRANT;
      end
      ARB_GRANT: begin
        // The served requester is excluded from the back-to-back pick; if it
        // is the only one left it is picked up again from IDLE.
        pick_ptr  = ptr_next;
        pick_mask = ~grant_q;
        if (grant_ack) begin
          ptr_d   = ptr_next;
          cnt_d   = '0;
          grant_d = win_oh;
          valid_d = win_any;
          if (!win_any) state_d = ARB_IDLE;
        end else if (WD_EN && (cnt_q == TO_LAST)) begin
          ptr_d   = ptr_next;
          cnt_d   = '0;
          grant_d = '0;
          valid_d = 1'b0;
          pulse_d = 1'b1;
          state_d = ARB_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_onehot  = grant_q;
  assign grant_valid   = valid_q;
  assign timeout_pulse = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_onehot_request_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rr_onehot_request_arbiter : directed + random bench with behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rr_onehot_request_arbiter;

  localparam int N       = 16;
  localparam int TIMEOUT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic         grant_ack = 1'b0;
  logic [N-1:0] grant_onehot;
  logic         grant_valid;
  logic         timeout_pulse;

  int total = 0;
  int bad   = 0;

  rr_onehot_request_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .TW(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .grant_onehot  (grant_onehot),
    .grant_valid   (grant_valid),
    .grant_ack     (grant_ack),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: who holds the grant, how long, and the search start.
  function automatic int search(input logic [N-1:0] r, input int p, input int excl);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  bit m_busy, n_busy, m_pulse, n_pulse;
  int m_ptr, n_ptr, m_g, n_g, m_held, n_held, w_idle, w_ack;

  always_comb begin
    n_busy  = m_busy;
    n_ptr   = m_ptr;
    n_g     = m_g;
    n_held  = m_held;
    n_pulse = 1'b0;
    w_idle  = search(req, m_ptr, -1);
    w_ack   = search(req, (m_g + 1) % N, m_g);
    if (!m_busy) begin
      if (w_idle >= 0) begin
        n_busy = 1'b1;
        n_g    = w_idle;
        n_held = 1;
      end
    end else if (grant_ack) begin
      n_ptr = (m_g + 1) % N;
      if (w_ack >= 0) begin
        n_g    = w_ack;
        n_held = 1;
      end else begin
        n_busy = 1'b0;
      end
    end else if (m_held == TIMEOUT) begin
      n_busy  = 1'b0;
      n_ptr   = (m_g + 1) % N;
      n_pulse = 1'b1;
    end else begin
      n_held = m_held + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_ptr <= 0; m_g <= 0; m_held <= 0; m_pulse <= 1'b0;
    end else begin
      m_busy <= n_busy; m_ptr <= n_ptr; m_g <= n_g; m_held <= n_held; m_pulse <= n_pulse;
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    logic [N-1:0] e;
    forever begin
      @(negedge clk);
      e = m_busy ? (N'(1) << m_g) : '0;
      chk("cmp_grant", 32'(grant_onehot), 32'(e));
      chk("cmp_valid", 32'(grant_valid), 32'(m_busy));
      chk("cmp_pulse", 32'(timeout_pulse), 32'(m_pulse));
      chk("cmp_onehot_inv", $countones(grant_onehot), grant_valid ? 32'd1 : 32'd0);
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] exp;
    req = '1; grant_ack = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_rst_grant", 32'(grant_onehot), 32'h0);
    chk("t1_rst_valid", 32'(grant_valid), 32'h0);
    chk("t1_rst_pulse", 32'(timeout_pulse), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_first", 32'(grant_onehot), 32'h0001);
    grant_ack = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp = 16'h0001 << (i % 16);
      chk("t1_rotate", 32'(grant_onehot), 32'(exp));
    end
    req = '0;
    @(negedge clk);
    chk("t1_idle_valid", 32'(grant_valid), 32'h0);
    grant_ack = 1'b0;

    do_reset();
    req = 16'h0041;
    @(negedge clk);
    chk("t2_first", 32'(grant_onehot), 32'h0001);
    grant_ack = 1'b1;
    @(negedge clk);
    chk("t2_second", 32'(grant_onehot), 32'h0040);
    @(negedge clk);
    chk("t2_third", 32'(grant_onehot), 32'h0001);
    req = '0;
    @(negedge clk);
    chk("t2_idle", 32'(grant_valid), 32'h0);
    grant_ack = 1'b0;

    req = 16'h0010;
    @(negedge clk);
    chk("t3_grant", 32'(grant_onehot), 32'h0010);
    req = '0;
    repeat (2) begin
      @(negedge clk);
      chk("t3_hold", 32'(grant_onehot), 32'h0010);
    end
    grant_ack = 1'b1;
    @(negedge clk);
    chk("t3_released_grant", 32'(grant_onehot), 32'h0);
    chk("t3_released_valid", 32'(grant_valid), 32'h0);
    grant_ack = 1'b0;

    req = 16'h0101;
    @(negedge clk);
    chk("t4_grant", 32'(grant_onehot), 32'h0100);
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold", 32'(grant_onehot), 32'h0100);
      chk("t4_no_pulse", 32'(timeout_pulse), 32'h0);
    end
    @(negedge clk);
    chk("t4_pulse", 32'(timeout_pulse), 32'h1);
    chk("t4_dropped", 32'(grant_valid), 32'h0);
    @(negedge clk);
    chk("t4_next", 32'(grant_onehot), 32'h0001);
    chk("t4_pulse_gone", 32'(timeout_pulse), 32'h0);

    repeat (2) @(negedge clk);
    chk("t5_still", 32'(grant_onehot), 32'h0001);
    grant_ack = 1'b1;
    @(negedge clk);
    chk("t5_no_pulse", 32'(timeout_pulse), 32'h0);
    chk("t5_advance", 32'(grant_onehot), 32'h0100);
    req = '0;
    @(negedge clk);
    grant_ack = 1'b0;

    req = 16'h0030;
    @(negedge clk);
    chk("t6_grant", 32'(grant_onehot), 32'h0010);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(grant_valid), 32'h0);
    chk("t6_async_grant", 32'(grant_onehot), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 16'h8001;
    @(negedge clk);
    chk("t6_ptr_zero", 32'(grant_onehot), 32'h0001);
    grant_ack = 1'b1; req = '0;
    @(negedge clk);
    grant_ack = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = '0;
      else req = N'($urandom & $urandom);
      grant_ack = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 499) == 0) do_reset();
      else @(negedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
